resized_crop_stream: RTL and testbench
======================================

RESIZED_CROP_STREAM -- requirements
Module: resized_crop_stream

Interface
REQ-001 SHALL have parameter SRC_W, default 28, meaning source image width in pixels.
REQ-002 SHALL have parameter SRC_H, default 28, meaning source image height in pixels.
REQ-003 SHALL have parameter DST_W, default 28, meaning output image width.
REQ-004 SHALL have parameter DST_H, default 28, meaning output image height.
REQ-005 SHALL have parameter PIX_W, default 8, meaning bits per channel.
REQ-006 SHALL have parameter CHANNELS, default 1, meaning channels packed per BRAM word, channel 0 in LSBs.
REQ-007 SHALL have parameter BRAM_LAT, default 1, meaning fixed cycles from bram_addr to valid bram_rdata (1..4).
REQ-008 SHALL have parameter FRAC, default 8, meaning fractional bits of step inputs.
REQ-009 SHALL have parameter ADDR_W, default 11, meaning BRAM word-address width.
REQ-010 SHALL have port clk, input, 1, the single clock; all logic on its rising edge.
REQ-011 SHALL have port reset, input, 1, asynchronous active-low reset (0 = in reset).
REQ-012 SHALL have port start, input, 1, one-cycle request to begin an image.
REQ-013 SHALL have ports crop_x and crop_y, input, $clog2(SRC_W) and $clog2(SRC_H), crop origin.
REQ-014 SHALL have ports step_x and step_y, input, 16, unsigned source step per output pixel in Q(16-FRAC).FRAC.
REQ-015 SHALL have port busy, output, 1, high from accepted start until done.
REQ-016 SHALL have port image_done, output, 1, one-cycle pulse when the source memory is no longer read for this image.
REQ-017 SHALL have ports bram_addr (output, ADDR_W) and bram_rdata (input, CHANNELS*PIX_W), word address and read data.
REQ-018 SHALL have ports pix_o (output, CHANNELS*PIX_W), pix_valid (output, 1) and pix_ready (input, 1), forming the output stream.

Function
REQ-019 SHALL latch crop_x, crop_y, step_x and step_y on the cycle start is sampled high in IDLE; later input changes SHALL have no effect on the current image.
REQ-020 SHALL implement states IDLE -> RUN on start; RUN -> DRAIN after the last address (ox=DST_W-1, oy=DST_H-1) is issued; DRAIN -> IDLE once the last pixel handshakes.
REQ-021 SHALL ignore start outside IDLE.
REQ-022 SHALL raise image_done for exactly one cycle in the cycle after the last BRAM read data is captured; the DRAIN -> IDLE transition occurs later.
REQ-023 SHALL compute source coordinates as sx = crop_x + floor(ox*step_x / 2^FRAC) and sy = crop_y + floor(oy*step_y / 2^FRAC), raster order with ox fastest.
REQ-024 SHALL evaluate sx and sy with per-column and per-row accumulators (no multipliers or dividers); the x accumulator SHALL clear at every row start.
REQ-025 SHALL use accumulators wide enough that no overflow occurs for any 16-bit step over DST_W or DST_H steps.
REQ-026 SHALL clamp sx to SRC_W-1 and sy to SRC_H-1 when exceeded (edge replication); no out-of-range address is ever issued.
REQ-027 SHALL drive bram_addr = sy*SRC_W + sx, truncated to ADDR_W bits, issuing at most one address per cycle.
REQ-028 SHALL buffer returned data in an output FIFO of depth BRAM_LAT+2.
REQ-029 SHALL issue an address only when FIFO occupancy plus reads in flight is less than BRAM_LAT+2, so no data is lost under any pix_ready pattern.
REQ-030 SHALL assert pix_valid whenever the FIFO is non-empty, with pix_o showing the FIFO head.
REQ-031 SHALL treat a transfer as occurring when pix_valid and pix_ready are both high.
REQ-032 SHALL hold pix_o and pix_valid stable while pix_valid=1 and pix_ready=0.
REQ-033 SHALL achieve one pixel per cycle when pix_ready is held high, with first pix_valid BRAM_LAT+1 cycles after start.
REQ-034 SHALL treat step 0 as valid: every output pixel on the row or column repeats the crop origin.

Reset
REQ-035 SHALL, while reset=0, immediately force state to IDLE, clear the FIFO and in-flight count, and drive busy=0, image_done=0, pix_valid=0, pix_o=0, bram_addr=0.
REQ-036 SHALL, on reset asserted mid-image, discard the image with no image_done pulse; after release, the block SHALL wait for a new start.

Verification
REQ-037 SHALL pass identity: crop (0,0), steps 0x0100, pix_ready=1 -> 784 pixels, pixel k = mem[k], image_done once, busy low after the last transfer.
REQ-038 SHALL pass 2x zoom: crop (7,7), steps 0x0080 -> pixel (ox,oy) = mem[(7+oy/2)*28 + 7+ox/2].
REQ-039 SHALL pass clamp: crop (20,0), step_x 0x0100 -> columns ox>=8 all read sx=27; bram_addr never exceeds 783.
REQ-040 SHALL pass backpressure: pix_ready random at 30% high, with BRAM_LAT=1 and BRAM_LAT=3 -> identical sequence to identity, no drop or duplicate, pix_o stable while stalled.
REQ-041 SHALL pass reset mid-image: reset low at pixel 300 -> all outputs 0 in the same cycle, no image_done; the next start produces a full correct image.
REQ-042 SHALL pass start while busy: start pulsed at pixel 100 with different crop -> ignored, image unchanged; CHANNELS=3 run -> all 24 bits passed through per pixel.

Source files
------------

// File: rtl/resized_crop_stream.sv
// resized_crop_stream: reads a cropped, nearest-neighbour resampled window out
// of a source image held in a fixed-latency BRAM and streams the pixels out on
// a valid/ready interface in raster order (ox fastest).
module resized_crop_stream #(
  parameter int SRC_W    = 28,
  parameter int SRC_H    = 28,
  parameter int DST_W    = 28,
  parameter int DST_H    = 28,
  parameter int PIX_W    = 8,
  parameter int CHANNELS = 1,
  parameter int BRAM_LAT = 1,
  parameter int FRAC     = 8,
  parameter int ADDR_W   = 11
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         start,
  input  logic [$clog2(SRC_W)-1:0]     crop_x,
  input  logic [$clog2(SRC_H)-1:0]     crop_y,
  input  logic [15:0]                  step_x,
  input  logic [15:0]                  step_y,
  output logic                         busy,
  output logic                         image_done,
  output logic [ADDR_W-1:0]            bram_addr,
  input  logic [CHANNELS*PIX_W-1:0]    bram_rdata,
  output logic [CHANNELS*PIX_W-1:0]    pix_o,
  output logic                         pix_valid,
  input  logic                         pix_ready
);

  localparam int CXW   = $clog2(SRC_W);
  localparam int CYW   = $clog2(SRC_H);
  localparam int DW    = CHANNELS * PIX_W;
  localparam int DEPTH = BRAM_LAT + 2;
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int OXW   = $clog2(DST_W + 1);
  localparam int OYW   = $clog2(DST_H + 1);
  // Wide enough for DST_W (DST_H) steps of the largest 16-bit step.
  localparam int AXW   = 16 + $clog2(DST_W + 1);
  localparam int AYW   = 16 + $clog2(DST_H + 1);
  localparam logic [BRAM_LAT-1:0] LAST_ONLY = BRAM_LAT'(1) << (BRAM_LAT - 1);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t              state_q, state_d;
  logic [CXW-1:0]      crop_x_q, crop_x_d;
  logic [CYW-1:0]      crop_y_q, crop_y_d;
  logic [15:0]         step_x_q, step_x_d;
  logic [15:0]         step_y_q, step_y_d;
  logic [OXW-1:0]      ox_q, ox_d;
  logic [OYW-1:0]      oy_q, oy_d;
  logic [AXW-1:0]      acc_x_q, acc_x_d;
  logic [AYW-1:0]      acc_y_q, acc_y_d;
  logic [BRAM_LAT-1:0] pipe_q, pipe_d;      // one bit per read in flight
  logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                done_q, done_d;
  logic [DW-1:0]       fifo_mem [DEPTH];

  logic [AXW:0]        sx_sum;
  logic [AYW:0]        sy_sum;
  logic [CXW-1:0]      sx;
  logic [CYW-1:0]      sy;
  logic [CNT_W-1:0]    inflight;
  logic [CNT_W:0]      occupancy;
  logic                has_room, issue, cap, pop, last_addr;

  // State register.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic: start only matters in IDLE; DRAIN ends on the last handshake.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (issue && last_addr) state_d = DRAIN;
      DRAIN:   if (pipe_q == '0 && cnt_q == CNT_W'(1) && pop) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs: busy flag and the address-issue strobe.
  always_comb begin
    busy  = (state_q != IDLE);
    issue = (state_q == RUN) && has_room;
  end

  // Source coordinate, clamping and word address for the current output pixel.
  always_comb begin
    sx_sum    = (AXW+1)'(crop_x_q) + (AXW+1)'(acc_x_q >> FRAC);
    sy_sum    = (AYW+1)'(crop_y_q) + (AYW+1)'(acc_y_q >> FRAC);
    sx        = (sx_sum > (AXW+1)'(SRC_W - 1)) ? CXW'(SRC_W - 1) : sx_sum[CXW-1:0];
    sy        = (sy_sum > (AYW+1)'(SRC_H - 1)) ? CYW'(SRC_H - 1) : sy_sum[CYW-1:0];
    bram_addr = ADDR_W'(sy) * ADDR_W'(SRC_W) + ADDR_W'(sx);
    last_addr = (ox_q == OXW'(DST_W - 1)) && (oy_q == OYW'(DST_H - 1));
  end

  // Credit check: FIFO occupancy plus reads in flight must leave a free slot.
  always_comb begin
    inflight = '0;
    for (int i = 0; i < BRAM_LAT; i++) inflight = inflight + CNT_W'(pipe_q[i]);
    occupancy = (CNT_W+1)'(cnt_q) + (CNT_W+1)'(inflight);
    has_room  = occupancy < (CNT_W+1)'(DEPTH);
    cap       = pipe_q[BRAM_LAT-1];
    pop       = pix_valid && pix_ready;
  end

  // Datapath next values: parameter latch, raster walk, read pipe, FIFO pointers.
  always_comb begin
    // NOTE: every combinational output gets a default first, so no path can infer a latch.
    crop_x_d = crop_x_q;
    crop_y_d = crop_y_q;
    step_x_d = step_x_q;
    step_y_d = step_y_q;
    ox_d     = ox_q;
    oy_d     = oy_q;
    acc_x_d  = acc_x_q;
    acc_y_d  = acc_y_q;
    if (state_q == IDLE && start) begin
      crop_x_d = crop_x;
      crop_y_d = crop_y;
      step_x_d = step_x;
      step_y_d = step_y;
      ox_d     = '0;
      oy_d     = '0;
      acc_x_d  = '0;
      acc_y_d  = '0;
    end
    if (issue) begin
      if (ox_q == OXW'(DST_W - 1)) begin
        ox_d    = '0;
        acc_x_d = '0;
        oy_d    = oy_q + OYW'(1);
        acc_y_d = acc_y_q + AYW'(step_y_q);
      end else begin
        ox_d    = ox_q + OXW'(1);
        acc_x_d = acc_x_q + AXW'(step_x_q);
      end
    end
    pipe_d    = pipe_q << 1;
    pipe_d[0] = issue;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    if (cap) wr_ptr_d = (wr_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr_q + PTR_W'(1);
    if (pop) rd_ptr_d = (rd_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr_q + PTR_W'(1);
    cnt_d  = cnt_q + CNT_W'(cap) - CNT_W'(pop);
    // The last read is the only one left at the final pipe stage once in DRAIN.
    done_d = (state_q == DRAIN) && (pipe_q == LAST_ONLY);
  end

  // Datapath registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      crop_x_q <= '0;
      crop_y_q <= '0;
      step_x_q <= '0;
      step_y_q <= '0;
      ox_q     <= '0;
      oy_q     <= '0;
      acc_x_q  <= '0;
      acc_y_q  <= '0;
      pipe_q   <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      done_q   <= 1'b0;
    end else begin
      crop_x_q <= crop_x_d;
      crop_y_q <= crop_y_d;
      step_x_q <= step_x_d;
      step_y_q <= step_y_d;
      ox_q     <= ox_d;
      oy_q     <= oy_d;
      acc_x_q  <= acc_x_d;
      acc_y_q  <= acc_y_d;
      pipe_q   <= pipe_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      done_q   <= done_d;
    end
  end

  // FIFO storage: captures BRAM data when the oldest read reaches the end of the pipe.
  // NOTE: the storage array has no reset; the count gates every read, so stale contents never escape.
  always_ff @(posedge clk) begin
    if (cap) fifo_mem[wr_ptr_q] <= bram_rdata;
  end

  assign pix_valid  = (cnt_q != '0);
  assign pix_o      = pix_valid ? fifo_mem[rd_ptr_q] : '0;
  assign image_done = done_q;

endmodule

// File: tb/tb_resized_crop_stream.sv
// Bench for resized_crop_stream: two instances (BRAM_LAT=1/1 channel and
// BRAM_LAT=3/3 channels), each fed from a behavioural BRAM. A reference model
// pushes expected pixels into a queue per instance; a monitor pops and compares.
module tb_resized_crop_stream;

  localparam int W = 28;
  localparam int H = 28;
  localparam int N = W * H;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n [2];
  logic        start [2];
  logic [4:0]  cx [2];
  logic [4:0]  cy [2];
  logic [15:0] stx [2];
  logic [15:0] sty [2];
  logic        rdy [2];
  logic        busy_w [2];
  logic        done_w [2];
  logic        pv_w [2];
  logic [10:0] addr_w [2];
  logic [23:0] pix_w [2];
  logic [7:0]  pix0, rd0;
  logic [23:0] pix1, rd1;

  logic [23:0] mem [N];
  logic [23:0] dp0;
  logic [23:0] dp1 [3];

  int          n_checks = 0;
  int          n_errors = 0;
  int          rdy_pct [2];
  int          pops [2];
  int          done_cnt [2];
  int          addr_max [2];
  logic        stalled [2];
  logic        idle_chk [2];
  logic [23:0] held [2];
  logic [23:0] exp0 [$];
  logic [23:0] exp1 [$];

  resized_crop_stream #(.BRAM_LAT(1), .CHANNELS(1)) u_dut0 (
    .clk(clk), .reset(rst_n[0]), .start(start[0]),
    .crop_x(cx[0]), .crop_y(cy[0]), .step_x(stx[0]), .step_y(sty[0]),
    .busy(busy_w[0]), .image_done(done_w[0]),
    .bram_addr(addr_w[0]), .bram_rdata(rd0),
    .pix_o(pix0), .pix_valid(pv_w[0]), .pix_ready(rdy[0])
  );

  resized_crop_stream #(.BRAM_LAT(3), .CHANNELS(3)) u_dut1 (
    .clk(clk), .reset(rst_n[1]), .start(start[1]),
    .crop_x(cx[1]), .crop_y(cy[1]), .step_x(stx[1]), .step_y(sty[1]),
    .busy(busy_w[1]), .image_done(done_w[1]),
    .bram_addr(addr_w[1]), .bram_rdata(rd1),
    .pix_o(pix1), .pix_valid(pv_w[1]), .pix_ready(rdy[1])
  );

  assign pix_w[0] = {16'h0, pix0};
  assign pix_w[1] = pix1;

  function automatic logic [23:0] rdmem(input logic [10:0] a);
    return (int'(a) < N) ? mem[a] : 24'hA5A5A5;
  endfunction

  // Behavioural BRAMs: one and three registered stages after the address.
  always @(posedge clk) begin
    dp0    <= rdmem(addr_w[0]);
    dp1[0] <= rdmem(addr_w[1]);
    dp1[1] <= dp1[0];
    dp1[2] <= dp1[1];
  end
  assign rd0 = dp0[7:0];
  assign rd1 = dp1[2];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int qsize(input int d);
    return (d == 0) ? exp0.size() : exp1.size();
  endfunction

  function automatic logic [23:0] qpop(input int d);
    return (d == 0) ? exp0.pop_front() : exp1.pop_front();
  endfunction

  function automatic void qpush(input int d, input logic [23:0] v);
    if (d == 0) exp0.push_back({16'h0, v[7:0]});
    else        exp1.push_back(v);
  endfunction

  // Ready generator: random pix_ready per instance at the requested duty.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      for (int d = 0; d < 2; d++) rdy[d] = ($urandom_range(99) < 32'(rdy_pct[d]));
    end
  end

  // Monitor: compares every handshake against the scoreboard and watches stalls.
  initial begin
    forever begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        if (!rst_n[d]) begin
          stalled[d]  = 1'b0;
          idle_chk[d] = 1'b0;
        end else begin
          if (idle_chk[d]) begin
            check("busy_after_last", 32'(busy_w[d]), 32'd0);
            idle_chk[d] = 1'b0;
          end
          if (stalled[d]) begin
            check("stall_valid", 32'(pv_w[d]), 32'd1);
            check("stall_data", 32'(pix_w[d]), 32'(held[d]));
          end
          if (pv_w[d] && rdy[d]) begin
            if (qsize(d) == 0) begin
              check("extra_pixel_valid", 32'(pv_w[d]), 32'd0);
            end else begin
              check("pixel", 32'(pix_w[d]), 32'(qpop(d)));
              pops[d]++;
              if (qsize(d) == 0) idle_chk[d] = 1'b1;
            end
          end
          stalled[d] = pv_w[d] && !rdy[d];
          held[d]    = pix_w[d];
          if (done_w[d]) begin
            done_cnt[d]++;
            check("done_while_busy", 32'(busy_w[d]), 32'd1);
          end
          if (busy_w[d] && int'(addr_w[d]) > addr_max[d]) addr_max[d] = int'(addr_w[d]);
        end
      end
    end
  end

  task automatic check_outputs_zero(input int d);
    check("rst_busy", 32'(busy_w[d]), 32'd0);
    check("rst_done", 32'(done_w[d]), 32'd0);
    check("rst_valid", 32'(pv_w[d]), 32'd0);
    check("rst_pix", 32'(pix_w[d]), 32'd0);
    check("rst_addr", 32'(addr_w[d]), 32'd0);
  endtask

  task automatic wait_pops(input int d, input int target);
    for (int i = 0; i < 20000; i++) begin
      @(negedge clk);
      if (pops[d] >= target) break;
    end
    if (pops[d] < target) check("wait_pixels", 32'(pops[d]), 32'(target));
  endtask

  // mode 0: plain image, 1: start pulsed while busy, 2: reset at pixel 300.
  task automatic run_image(input int d, input int cxi, input int cyi, input int sxi,
                           input int syi, input int pct, input int mode);
    int   base, lat_cnt, xs, ys;
    logic ok;
    rdy_pct[d] = pct;
    for (int oy = 0; oy < H; oy++) begin
      for (int ox = 0; ox < W; ox++) begin
        xs = cxi + ((ox * sxi) / 256);
        ys = cyi + ((oy * syi) / 256);
        if (xs > W - 1) xs = W - 1;
        if (ys > H - 1) ys = H - 1;
        qpush(d, mem[ys * W + xs]);
      end
    end
    done_cnt[d] = 0;
    addr_max[d] = 0;
    base        = pops[d];
    @(posedge clk);
    #1;
    cx[d]    = 5'(cxi);
    cy[d]    = 5'(cyi);
    stx[d]   = 16'(sxi);
    sty[d]   = 16'(syi);
    start[d] = 1'b1;
    @(posedge clk);
    #1;
    start[d] = 1'b0;
    cx[d]    = 5'($urandom_range(27));
    cy[d]    = 5'($urandom_range(27));
    stx[d]   = 16'($urandom);
    sty[d]   = 16'($urandom);
    lat_cnt  = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (pv_w[d]) break;
      lat_cnt++;
    end
    check("first_valid_latency", 32'(lat_cnt), (d == 0) ? 32'd2 : 32'd4);
    if (mode == 1) begin
      wait_pops(d, base + 100);
      @(posedge clk);
      #1;
      cx[d]    = 5'd1;
      cy[d]    = 5'd2;
      stx[d]   = 16'h0040;
      sty[d]   = 16'h0300;
      start[d] = 1'b1;
      @(posedge clk);
      #1;
      start[d] = 1'b0;
    end
    if (mode == 2) begin
      wait_pops(d, base + 300);
      @(negedge clk);
      #2;
      rst_n[d] = 1'b0;
      #1;
      check_outputs_zero(d);
      if (d == 0) exp0.delete();
      else        exp1.delete();
      repeat (4) @(posedge clk);
      check("no_done_after_reset", 32'(done_cnt[d]), 32'd0);
      @(negedge clk);
      rst_n[d] = 1'b1;
      return;
    end
    ok = 1'b0;
    for (int i = 0; i < N * 8 + 200; i++) begin
      @(negedge clk);
      if (qsize(d) == 0 && !busy_w[d]) begin
        ok = 1'b1;
        break;
      end
    end
    check("image_complete", 32'(ok), 32'd1);
    check("done_pulses", 32'(done_cnt[d]), 32'd1);
    check("addr_in_range", 32'(addr_max[d] <= N - 1), 32'd1);
    repeat (2) @(posedge clk);
  endtask

  initial begin
    for (int i = 0; i < N; i++) mem[i] = 24'($urandom);
    for (int d = 0; d < 2; d++) begin
      rst_n[d]    = 1'b0;
      start[d]    = 1'b0;
      cx[d]       = '0;
      cy[d]       = '0;
      stx[d]      = '0;
      sty[d]      = '0;
      rdy[d]      = 1'b1;
      rdy_pct[d]  = 100;
      pops[d]     = 0;
      done_cnt[d] = 0;
      addr_max[d] = 0;
      stalled[d]  = 1'b0;
      idle_chk[d] = 1'b0;
      held[d]     = '0;
    end
    repeat (3) @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) check_outputs_zero(d);
    @(negedge clk);
    rst_n[0] = 1'b1;
    rst_n[1] = 1'b1;
    for (int d = 0; d < 2; d++) begin
      run_image(d, 0, 0, 256, 256, 100, 0);                 // identity
      run_image(d, 7, 7, 128, 128, 100, 0);                 // 2x zoom
      run_image(d, 20, 0, 256, 256, 100, 0);                // right-edge clamp
      run_image(d, 0, 0, 256, 256, 30, 0);                  // backpressure
      run_image(d, 5, 9, 0, 0, 70, 0);                      // zero step
      run_image(d, int'($urandom_range(27)), int'($urandom_range(27)),
                int'($urandom_range(1023)), int'($urandom_range(1023)), 50, 0);
      run_image(d, 3, 4, 256, 256, 100, 1);                 // start while busy
      run_image(d, 0, 0, 256, 256, 100, 2);                 // reset mid-image
      run_image(d, 0, 0, 256, 256, 100, 0);                 // full image after reset
    end
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
